// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared constants, encodings and sizing helper for the HDMI data-island scheduler.
package hdmi_island_scheduler_pkg;

    localparam int PREAMBLE_LEN    = 8;
    localparam int GUARD_LEN       = 2;
    localparam int PKT_LEN         = 32;
    localparam int MAX_ISLAND_PKTS = 18;

    typedef enum logic [1:0] {
        SEL_ACR   = 2'd0,
        SEL_AUDIO = 2'd1,
        SEL_AVI   = 2'd2,
        SEL_AIF   = 2'd3
    } pkt_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_LGUARD = 3'd2,
        ST_PKT    = 3'd3,
        ST_TGUARD = 3'd4
    } island_state_e;

    // Packet slots that fit between the island start and the end of the line,
    // keeping 10 pixels of control period and 12 pixels of island framing.
    function automatic int calc_max_pkts(input int framewidth, input int width_max,
                                         input int start_offs);
        int room;
        room = (width_max - 10 - (framewidth + start_offs) - 12) / PKT_LEN;
        if (room > MAX_ISLAND_PKTS) begin
            return MAX_ISLAND_PKTS;
        end else if (room < 0) begin
            return 0;
        end else begin
            return room;
        end
    endfunction

    localparam int MAX_PKTS_1080P = calc_max_pkts(1920, 2200, 4);
    localparam int MAX_PKTS_720P  = calc_max_pkts(1280, 1650, 4);

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// Timing-counter inputs and island phase/grant outputs of the island scheduler.
interface hdmi_island_scheduler_if;
    logic [11:0] hCnt;
    logic [10:0] vCnt;
    logic        acr_tick;
    logic [4:0]  audio_cnt;
    logic        island_active;
    logic        preamble;
    logic        guard;
    logic        pkt_valid;
    logic        pkt_start;
    logic [1:0]  pkt_sel;
    logic [4:0]  pkt_idx;
    logic [3:0]  grant;
    logic        info_miss;

    modport master (
        output hCnt, vCnt, acr_tick, audio_cnt,
        input  island_active, preamble, guard, pkt_valid, pkt_start,
               pkt_sel, pkt_idx, grant, info_miss
    );

    modport slave (
        input  hCnt, vCnt, acr_tick, audio_cnt,
        output island_active, preamble, guard, pkt_valid, pkt_start,
               pkt_sel, pkt_idx, grant, info_miss
    );
endinterface

// File: rtl/hdmi_island_scheduler_prio_pick.sv
// Combinational slot-owner picker; priority order depends on active vs blanking line.
module hdmi_pkt_prio_pick
    import hdmi_island_scheduler_pkg::*;
(
    input  logic [3:0] pend,
    input  logic       audio_ok,
    input  logic       blank,
    output logic [3:0] grant,
    output pkt_sel_e   sel,
    output logic       any
);

    logic [3:0] elig_s;

    // Active lines favour audio after ACR; blanking lines push audio to last.
    always_comb begin
        elig_s = {pend[3], pend[2], pend[1] & audio_ok, pend[0]};
        grant  = 4'b0000;
        sel    = SEL_ACR;
        if (elig_s[0]) begin
            grant = 4'b0001;
            sel   = SEL_ACR;
        end else if (!blank && elig_s[1]) begin
            grant = 4'b0010;
            sel   = SEL_AUDIO;
        end else if (elig_s[2]) begin
            grant = 4'b0100;
            sel   = SEL_AVI;
        end else if (elig_s[3]) begin
            grant = 4'b1000;
            sel   = SEL_AIF;
        end else if (elig_s[1]) begin
            grant = 4'b0010;
            sel   = SEL_AUDIO;
        end else begin
            grant = 4'b0000;
            sel   = SEL_ACR;
        end
        any = (elig_s != 4'b0000);
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Places one data island in each horizontal blanking interval and hands its packet
// slots to ACR, audio, AVI and audio InfoFrame sources by priority.
module hdmi_island_scheduler
    import hdmi_island_scheduler_pkg::*;
#(
    parameter int FRAMEWIDTH  = 1920,
    parameter int FRAMEHEIGHT = 1080,
    parameter int WIDTH_MAX   = 2200,
    parameter int START_OFFS  = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    hdmi_island_scheduler_if.slave bus
);

    localparam int          MAX_PKTS   = calc_max_pkts(FRAMEWIDTH, WIDTH_MAX, START_OFFS);
    localparam logic [5:0]  MAX_PKTS_W = 6'(MAX_PKTS);
    localparam logic [11:0] DECIDE_H   = 12'(FRAMEWIDTH + START_OFFS - 1);
    localparam logic [10:0] BLANK_V    = 11'(FRAMEHEIGHT);
    localparam logic [4:0]  PRE_LAST   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]  GUARD_LAST = 5'(GUARD_LEN - 1);
    localparam logic [4:0]  PKT_LAST   = 5'(PKT_LEN - 1);

    island_state_e state_r;
    logic [4:0]    cnt_r;
    logic [4:0]    slots_left_r;
    logic [4:0]    audio_left_r;
    logic          acr_pend_r;
    logic          avi_pend_r;
    logic          aif_pend_r;
    logic          info_miss_r;
    logic          island_active_r;
    logic          preamble_r;
    logic          guard_r;
    logic          pkt_valid_r;
    logic          pkt_start_r;
    logic [1:0]    pkt_sel_r;
    logic [4:0]    pkt_idx_r;
    logic [3:0]    grant_r;

    logic [5:0]    pend_sum_s;
    logic [5:0]    n_s;
    logic [4:0]    audio_n_s;
    logic          wrap_s;
    logic          decide_s;
    logic          blank_s;
    logic          frame_start_s;
    logic          slot_end_s;
    logic          slot_go_s;
    logic          take_slot_s;
    logic [3:0]    pick_grant_s;
    pkt_sel_e      pick_sel_s;
    logic          pick_any_s;

    // Slot budget for the upcoming island and per-cycle event decode.
    always_comb begin
        pend_sum_s    = {5'd0, acr_pend_r} + {5'd0, avi_pend_r} + {5'd0, aif_pend_r}
                      + {1'b0, bus.audio_cnt};
        n_s           = (pend_sum_s > MAX_PKTS_W) ? MAX_PKTS_W : pend_sum_s;
        audio_n_s     = (bus.audio_cnt > n_s[4:0]) ? n_s[4:0] : bus.audio_cnt;
        wrap_s        = (bus.hCnt == 12'd0);
        decide_s      = (bus.hCnt == DECIDE_H);
        blank_s       = (bus.vCnt >= BLANK_V);
        frame_start_s = wrap_s && (bus.vCnt == 11'd0);
        slot_end_s    = ((state_r == ST_LGUARD) && (cnt_r == GUARD_LAST))
                     || ((state_r == ST_PKT) && (cnt_r == PKT_LAST));
        slot_go_s     = !wrap_s && slot_end_s
                     && ((state_r == ST_LGUARD) || (slots_left_r != 5'd0));
        take_slot_s   = slot_go_s && pick_any_s;
    end

    hdmi_pkt_prio_pick u_pick (
        .pend     ({aif_pend_r, avi_pend_r, (bus.audio_cnt != 5'd0), acr_pend_r}),
        .audio_ok (audio_left_r != 5'd0),
        .blank    (blank_s),
        .grant    (pick_grant_s),
        .sel      (pick_sel_s),
        .any      (pick_any_s)
    );

    // Pending flags; a fresh ACR tick wins over the grant that would clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acr_pend_r  <= 1'b0;
            avi_pend_r  <= 1'b1;
            aif_pend_r  <= 1'b1;
            info_miss_r <= 1'b0;
        end else begin
            if (bus.acr_tick) begin
                acr_pend_r <= 1'b1;
            end else if (take_slot_s && pick_grant_s[0]) begin
                acr_pend_r <= 1'b0;
            end else begin
                acr_pend_r <= acr_pend_r;
            end
            if (frame_start_s) begin
                info_miss_r <= info_miss_r | avi_pend_r | aif_pend_r;
                avi_pend_r  <= 1'b1;
                aif_pend_r  <= 1'b1;
            end else begin
                info_miss_r <= info_miss_r;
                avi_pend_r  <= avi_pend_r & ~(take_slot_s & pick_grant_s[2]);
                aif_pend_r  <= aif_pend_r & ~(take_slot_s & pick_grant_s[3]);
            end
        end
    end

    // Island FSM; outputs are set from the transition so they lag hCnt by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 5'd0;
            slots_left_r    <= 5'd0;
            audio_left_r    <= 5'd0;
            island_active_r <= 1'b0;
            preamble_r      <= 1'b0;
            guard_r         <= 1'b0;
            pkt_valid_r     <= 1'b0;
            pkt_start_r     <= 1'b0;
            pkt_sel_r       <= 2'd0;
            pkt_idx_r       <= 5'd0;
            grant_r         <= 4'b0000;
        end else begin
            pkt_start_r <= 1'b0;
            grant_r     <= 4'b0000;
            if (wrap_s) begin
                // An island still open at line wrap is abandoned.
                state_r         <= ST_IDLE;
                cnt_r           <= 5'd0;
                island_active_r <= 1'b0;
                preamble_r      <= 1'b0;
                guard_r         <= 1'b0;
                pkt_valid_r     <= 1'b0;
                pkt_idx_r       <= 5'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (decide_s && (n_s != 6'd0)) begin
                            state_r         <= ST_PRE;
                            cnt_r           <= 5'd0;
                            slots_left_r    <= n_s[4:0];
                            audio_left_r    <= audio_n_s;
                            island_active_r <= 1'b1;
                            preamble_r      <= 1'b1;
                        end else begin
                            island_active_r <= 1'b0;
                            preamble_r      <= 1'b0;
                        end
                        guard_r     <= 1'b0;
                        pkt_valid_r <= 1'b0;
                        pkt_idx_r   <= 5'd0;
                    end
                    ST_PRE: begin
                        if (cnt_r == PRE_LAST) begin
                            state_r    <= ST_LGUARD;
                            cnt_r      <= 5'd0;
                            preamble_r <= 1'b0;
                            guard_r    <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                    ST_LGUARD, ST_PKT: begin
                        if (take_slot_s) begin
                            state_r      <= ST_PKT;
                            cnt_r        <= 5'd0;
                            guard_r      <= 1'b0;
                            pkt_valid_r  <= 1'b1;
                            pkt_start_r  <= 1'b1;
                            pkt_idx_r    <= 5'd0;
                            pkt_sel_r    <= pick_sel_s;
                            grant_r      <= pick_grant_s;
                            slots_left_r <= slots_left_r - 5'd1;
                            if (pick_grant_s[1]) begin
                                audio_left_r <= audio_left_r - 5'd1;
                            end else begin
                                audio_left_r <= audio_left_r;
                            end
                        end else if (slot_end_s) begin
                            state_r     <= ST_TGUARD;
                            cnt_r       <= 5'd0;
                            guard_r     <= 1'b1;
                            pkt_valid_r <= 1'b0;
                            pkt_idx_r   <= 5'd0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                            if (state_r == ST_PKT) begin
                                pkt_idx_r <= cnt_r + 5'd1;
                            end else begin
                                pkt_idx_r <= 5'd0;
                            end
                        end
                    end
                    ST_TGUARD: begin
                        if (cnt_r == GUARD_LAST) begin
                            state_r         <= ST_IDLE;
                            cnt_r           <= 5'd0;
                            guard_r         <= 1'b0;
                            island_active_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                    default: begin
                        state_r         <= ST_IDLE;
                        cnt_r           <= 5'd0;
                        island_active_r <= 1'b0;
                        preamble_r      <= 1'b0;
                        guard_r         <= 1'b0;
                        pkt_valid_r     <= 1'b0;
                        pkt_idx_r       <= 5'd0;
                    end
                endcase
            end
        end
    end

    assign bus.island_active = island_active_r;
    assign bus.preamble      = preamble_r;
    assign bus.guard         = guard_r;
    assign bus.pkt_valid     = pkt_valid_r;
    assign bus.pkt_start     = pkt_start_r;
    assign bus.pkt_sel       = pkt_sel_r;
    assign bus.pkt_idx       = pkt_idx_r;
    assign bus.grant         = grant_r;
    assign bus.info_miss     = info_miss_r;

endmodule
